// File: rtl/reaction_round_scheduler_if.sv
// Bundle of game-facing signals between the reaction-time scheduler and its
// surroundings: button/tick/random sources in, LED bank and score outputs out.
interface reaction_round_scheduler_if #(
  parameter int MAX_MS     = 2047,
  parameter int LED_NUM    = 18,
  parameter int NUM_ROUNDS = 4
);
  localparam int MS_W  = $clog2(MAX_MS + 1);
  localparam int RW    = $clog2(NUM_ROUNDS);
  localparam int LED_W = $clog2(LED_NUM);

  logic                 start;
  logic                 button_pressed;
  logic                 ms_tick;
  logic [LED_W-1:0]     random_value;
  logic [MS_W-1:0]      random_delay;
  logic [LED_NUM-1:0]   led_on;
  logic [RW-1:0]        round_idx;
  logic [MS_W-1:0]      last_time;
  logic [MS_W-1:0]      best_time;
  logic [MS_W+RW-1:0]   total_time;
  logic                 result_valid;
  logic                 false_start;
  logic                 busy;
  logic                 done;

  // Environment side: drives the sources, observes the results.
  modport master (
    output start, button_pressed, ms_tick, random_value, random_delay,
    input  led_on, round_idx, last_time, best_time, total_time,
           result_valid, false_start, busy, done
  );

  // Scheduler side.
  modport slave (
    input  start, button_pressed, ms_tick, random_value, random_delay,
    output led_on, round_idx, last_time, best_time, total_time,
           result_valid, false_start, busy, done
  );
endinterface

// File: rtl/reaction_round_scheduler.sv
// Multi-round reaction-time sequencer: random pre-delay, one random LED,
// millisecond timing of the press, false-start and timeout handling, and
// last/best/total result bookkeeping. Every output is a register.
module reaction_round_scheduler #(
  parameter int MAX_MS          = 2047,
  parameter int LED_NUM         = 18,
  parameter int NUM_ROUNDS      = 4,
  parameter int MAX_TIME_LED_ON = 1000,
  parameter int MIN_DELAY_MS    = 500,
  parameter int PENALTY_MS      = 300
) (
  input logic                        clk,
  input logic                        reset,
  reaction_round_scheduler_if.slave  bus
);
  localparam int MS_W  = $clog2(MAX_MS + 1);
  localparam int RW    = $clog2(NUM_ROUNDS);
  localparam int LED_W = $clog2(LED_NUM);
  localparam int TOT_W = MS_W + RW;

  localparam logic [MS_W-1:0] TIMEOUT_MS   = MS_W'(MAX_TIME_LED_ON);
  localparam logic [MS_W-1:0] TIMEOUT_LAST = MS_W'(MAX_TIME_LED_ON - 1);
  localparam logic [MS_W-1:0] MIN_DELAY    = MS_W'(MIN_DELAY_MS);
  localparam logic [MS_W-1:0] DELAY_CAP    = MS_W'(MAX_MS - 1);
  localparam logic [MS_W-1:0] PENALTY_LAST = MS_W'(PENALTY_MS - 1);
  localparam logic [RW-1:0]   LAST_ROUND   = RW'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DELAY,
    S_ARMED,
    S_PENALTY,
    S_RECORD,
    S_SUMMARY
  } state_e;

  state_e               state_q;
  logic                 start_q;
  logic                 button_q;
  logic [MS_W-1:0]      ms_cnt_q;
  logic [MS_W-1:0]      delay_q;
  logic [LED_NUM-1:0]   led_on_q;
  logic [RW-1:0]        round_idx_q;
  logic [MS_W-1:0]      last_time_q;
  logic [MS_W-1:0]      best_time_q;
  logic [TOT_W-1:0]     total_time_q;
  logic                 result_valid_q;
  logic                 false_start_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 start_edge;
  logic                 button_edge;
  logic [MS_W-1:0]      delay_d;
  logic [LED_W-1:0]     led_idx_d;
  logic [LED_NUM-1:0]   led_on_d;

  // Remember previous input levels so rising edges can be detected.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples pre-edge values and simulation order cannot change the result.
    if (reset) begin
      start_q  <= 1'b0;
      button_q <= 1'b0;
    end else begin
      start_q  <= bus.start;
      button_q <= bus.button_pressed;
    end
  end

  assign start_edge  = bus.start & ~start_q;
  assign button_edge = bus.button_pressed & ~button_q;

  // Candidate delay and LED pattern, latched only on the relevant transitions.
  always_comb begin
    // NOTE: every variable gets a default at the top of the block, so no path
    // leaves it unassigned and no latch is inferred.
    delay_d   = bus.random_delay;
    led_idx_d = bus.random_value;
    if (delay_d > DELAY_CAP) delay_d = DELAY_CAP;
    if (delay_d < MIN_DELAY) delay_d = MIN_DELAY;
    if (int'(bus.random_value) >= LED_NUM) led_idx_d = bus.random_value - LED_W'(LED_NUM);
    led_on_d = LED_NUM'(1) << led_idx_d;
  end

  // Round sequencer; outputs are updated on the transitions that imply them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ms_cnt_q       <= '0;
      delay_q        <= '0;
      led_on_q       <= '0;
      round_idx_q    <= '0;
      last_time_q    <= '0;
      best_time_q    <= TIMEOUT_MS;
      total_time_q   <= '0;
      result_valid_q <= 1'b0;
      false_start_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      false_start_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_SUMMARY: begin
          if (start_edge) begin
            round_idx_q  <= '0;
            total_time_q <= '0;
            ms_cnt_q     <= '0;
            best_time_q  <= TIMEOUT_MS;
            delay_q      <= delay_d;
            led_on_q     <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            state_q      <= S_WAIT_DELAY;
          end
        end

        S_WAIT_DELAY: begin
          if (button_edge) begin
            false_start_q <= 1'b1;
            ms_cnt_q      <= '0;
            led_on_q      <= '1;
            state_q       <= S_PENALTY;
          end else if (bus.ms_tick) begin
            if (ms_cnt_q == delay_q - MS_W'(1)) begin
              ms_cnt_q <= '0;
              led_on_q <= led_on_d;
              state_q  <= S_ARMED;
            end else begin
              ms_cnt_q <= ms_cnt_q + MS_W'(1);
            end
          end
        end

        S_ARMED: begin
          if (button_edge) begin
            last_time_q <= ms_cnt_q;
            led_on_q    <= '0;
            state_q     <= S_RECORD;
          end else if (bus.ms_tick) begin
            if (ms_cnt_q == TIMEOUT_LAST) begin
              last_time_q <= TIMEOUT_MS;
              led_on_q    <= '0;
              state_q     <= S_RECORD;
            end else begin
              ms_cnt_q <= ms_cnt_q + MS_W'(1);
            end
          end
        end

        S_PENALTY: begin
          if (bus.ms_tick) begin
            if (ms_cnt_q == PENALTY_LAST) begin
              last_time_q <= TIMEOUT_MS;
              led_on_q    <= '0;
              state_q     <= S_RECORD;
            end else begin
              ms_cnt_q <= ms_cnt_q + MS_W'(1);
            end
          end
        end

        S_RECORD: begin
          total_time_q   <= total_time_q + {{RW{1'b0}}, last_time_q};
          best_time_q    <= (last_time_q < best_time_q) ? last_time_q : best_time_q;
          result_valid_q <= 1'b1;
          if (round_idx_q == LAST_ROUND) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_SUMMARY;
          end else begin
            round_idx_q <= round_idx_q + RW'(1);
            delay_q     <= delay_d;
            ms_cnt_q    <= '0;
            state_q     <= S_WAIT_DELAY;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.led_on       = led_on_q;
  assign bus.round_idx    = round_idx_q;
  assign bus.last_time    = last_time_q;
  assign bus.best_time    = best_time_q;
  assign bus.total_time   = total_time_q;
  assign bus.result_valid = result_valid_q;
  assign bus.false_start  = false_start_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_reaction_round_scheduler.sv
// Directed bench for reaction_round_scheduler with a two-round game and a
// millisecond tick every clock. Inputs change and outputs are sampled on the
// falling edge; the DUT acts on the rising edge.
module tb_reaction_round_scheduler;
  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;
  int   n;

  localparam logic [17:0] ALL_ON = 18'h3FFFF;

  reaction_round_scheduler_if #(.MAX_MS(2047), .LED_NUM(18), .NUM_ROUNDS(2)) bus ();

  reaction_round_scheduler #(
    .MAX_MS(2047), .LED_NUM(18), .NUM_ROUNDS(2),
    .MAX_TIME_LED_ON(1000), .MIN_DELAY_MS(500), .PENALTY_MS(300)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Count falling edges until led_on differs from v (bounded).
  task automatic wait_while_led(input logic [17:0] v, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.led_on == v && cnt < 5000);
  endtask

  // One-cycle start pulse; returns on the first WAIT_DELAY cycle.
  task automatic start_game();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Press after k more cycles of ARMED, then check the record and result cycles.
  task automatic press_and_record(input int k, input string tag);
    repeat (k) @(negedge clk);
    bus.button_pressed = 1'b1;
    @(negedge clk);
    check({tag, "_last"}, bus.last_time, k);
    check({tag, "_led_off"}, bus.led_on, 0);
    check({tag, "_rv_early"}, bus.result_valid, 0);
    bus.button_pressed = 1'b0;
    @(negedge clk);
    check({tag, "_rv"}, bus.result_valid, 1);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.button_pressed = 1'b0;
    bus.ms_tick = 1'b1;
    bus.random_value = 5'd3;
    bus.random_delay = 11'd600;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_led", bus.led_on, 0);
    check("rst_best", bus.best_time, 1000);
    check("rst_total", bus.total_time, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    reset = 1'b0;
    @(negedge clk);

    // Game 1: two answered rounds, 42 then 100
    start_game();
    check("g1_busy", bus.busy, 1);
    wait_while_led(18'h0, n);
    check("g1_delay600", n, 600);
    check("g1_led", bus.led_on, 18'h8);
    press_and_record(42, "g1r0");
    check("g1r0_total", bus.total_time, 42);
    check("g1r0_best", bus.best_time, 42);
    check("g1r0_round", bus.round_idx, 1);
    wait_while_led(18'h0, n);
    check("g1r1_delay600", n, 600);
    press_and_record(100, "g1r1");
    check("g1_total", bus.total_time, 142);
    check("g1_best", bus.best_time, 42);
    check("g1_done", bus.done, 1);
    check("g1_busy_end", bus.busy, 0);
    check("g1_round_end", bus.round_idx, 1);
    @(negedge clk);
    check("g1_rv_pulse", bus.result_valid, 0);
    check("g1_hold_total", bus.total_time, 142);

    // Game 2: delay floor, index wrap, timeout, then false start at tick 200
    bus.random_delay = 11'd100;
    bus.random_value = 5'd20;
    start_game();
    check("g2_best_reinit", bus.best_time, 1000);
    check("g2_done_clr", bus.done, 0);
    wait_while_led(18'h0, n);
    check("g2_delay_floor", n, 500);
    check("g2_led_wrap", bus.led_on, 18'h4);
    wait_while_led(18'h4, n);
    check("g2_timeout_len", n, 1000);
    check("g2_timeout_last", bus.last_time, 1000);
    @(negedge clk);
    check("g2r0_rv", bus.result_valid, 1);
    check("g2r0_round", bus.round_idx, 1);
    check("g2r0_total", bus.total_time, 1000);
    repeat (200) @(negedge clk);
    bus.button_pressed = 1'b1;
    @(negedge clk);
    check("g2_fs_pulse", bus.false_start, 1);
    check("g2_fs_leds", bus.led_on, ALL_ON);
    @(negedge clk);
    check("g2_fs_once", bus.false_start, 0);
    bus.button_pressed = 1'b0;
    wait_while_led(ALL_ON, n);
    check("g2_penalty_len", n, 299);
    check("g2_pen_last", bus.last_time, 1000);
    check("g2_pen_led_off", bus.led_on, 0);
    @(negedge clk);
    check("g2_pen_rv", bus.result_valid, 1);
    check("g2_total", bus.total_time, 2000);
    check("g2_best", bus.best_time, 1000);
    check("g2_done", bus.done, 1);

    // Game 3: press on the final delay tick, then press on the timeout tick
    bus.random_delay = 11'd600;
    bus.random_value = 5'd3;
    start_game();
    repeat (599) @(negedge clk);
    bus.button_pressed = 1'b1;
    @(negedge clk);
    check("g3_tie_fs", bus.false_start, 1);
    check("g3_tie_leds", bus.led_on, ALL_ON);
    bus.button_pressed = 1'b0;
    wait_while_led(ALL_ON, n);
    @(negedge clk);
    check("g3r0_rv", bus.result_valid, 1);
    wait_while_led(18'h0, n);
    check("g3r1_led", bus.led_on, 18'h8);
    press_and_record(999, "g3_tie_to");
    check("g3_total", bus.total_time, 1999);
    check("g3_best", bus.best_time, 999);

    // Game 4: reset in ARMED of round 1, button held through reset
    start_game();
    wait_while_led(18'h0, n);
    press_and_record(10, "g4r0");
    wait_while_led(18'h0, n);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    bus.button_pressed = 1'b1;
    @(negedge clk);
    check("g4_rst_busy", bus.busy, 0);
    check("g4_rst_led", bus.led_on, 0);
    check("g4_rst_total", bus.total_time, 0);
    check("g4_rst_best", bus.best_time, 1000);
    check("g4_rst_round", bus.round_idx, 0);
    check("g4_rst_last", bus.last_time, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("g4_idle_busy", bus.busy, 0);
    check("g4_idle_led", bus.led_on, 0);
    check("g4_idle_fs", bus.false_start, 0);
    check("g4_idle_done", bus.done, 0);
    bus.button_pressed = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
